// File: rtl/uart_pkg.sv
// Shared types and elaboration-time helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    // Bit period in clock cycles, rounded to the nearest whole cycle.
    function automatic int baud_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock byte FIFO with occupancy count; head word is visible on rdata.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       wdata,
    output logic [WIDTH-1:0]       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic [LVL_W-1:0] level_d;
    logic             do_push;
    logic             do_pop;

    // Fullness comes from the registered level only, so a same-cycle pop never frees a slot.
    assign full    = (level_q == LVL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign level   = level_q;

    always_comb begin
        level_d = level_q;
        if (do_push && !do_pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (!do_push && do_pop) begin
            level_d = level_q - LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            level_q <= level_d;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a registered serializer FSM.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 12000000,
    parameter int BAUD     = 115200,
    parameter int DEPTH    = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [7:0]             in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   uart_tx,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] level
);
    localparam int DIV   = baud_div(CLK_FREQ, BAUD);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_q;
    logic [7:0]       shift_q;
    logic             tx_q;
    logic             line_busy_q;

    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic             pop;
    logic             bit_end;

    assign bit_end = (cnt_q == CNT_LAST);
    assign pop     = !fifo_empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (in_valid),
        .pop    (pop),
        .wdata  (in_data),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    // The line register trails the state by one cycle, so busy also covers that trailing cycle.
    assign in_ready = !fifo_full;
    assign busy     = (state_q != IDLE) || !fifo_empty || line_busy_q;
    assign uart_tx  = tx_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            line_busy_q <= 1'b0;
        end else begin
            line_busy_q <= (state_q != IDLE);
            case (state_q)
                START:   tx_q <= 1'b0;
                DATA:    tx_q <= shift_q[0];
                default: tx_q <= 1'b1;
            endcase

            case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= fifo_rdata;
                        cnt_q   <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        shift_q <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (pop) begin
                            shift_q <= fifo_rdata;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench: cycle timeline model of accepted bytes and their frames.
module tb_uart_tx_fifo;
    localparam int DEPTH = 4;
    localparam int DIV   = 10;
    localparam int FRAME = 10 * DIV;

    logic       clk;
    logic       resetn;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       uart_tx;
    logic       busy;
    logic [2:0] level;

    uart_tx_fifo #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .DEPTH    (DEPTH)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .uart_tx  (uart_tx),
        .busy     (busy),
        .level    (level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         t;
    int         n_checks;
    int         n_fail;
    int         fstart [4096];
    logic [7:0] fdata  [4096];
    int         nf;
    int         fh;
    int         pp;
    int         acc;
    int         last_start;
    bit         last_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        nf = 0; fh = 0; pp = 0; acc = 0; last_start = -1000; last_acc = 0;
    endtask

    // One clock: apply the acceptance/timing rules at the edge, compare outputs at the falling edge.
    task automatic step();
        int   lvl_before;
        int   s;
        int   k;
        logic exp_tx;
        int   exp_lvl;
        logic exp_busy;
        @(posedge clk);
        t++;
        last_acc = 0;
        if (!resetn) begin
            model_reset();
        end else begin
            lvl_before = acc - pp;
            if (in_valid && (lvl_before != DEPTH)) begin
                last_acc = 1;
                s = (t + 2 > last_start + FRAME) ? t + 2 : last_start + FRAME;
                fstart[nf] = s;
                fdata[nf]  = in_data;
                nf++;
                acc++;
                last_start = s;
                $display("push %02h at cycle %0d, start bit due at %0d", in_data, t, s);
            end
            while (pp < nf && fstart[pp] - 1 <= t) pp++;
        end
        while (fh < nf && t >= fstart[fh] + FRAME) fh++;
        @(negedge clk);
        exp_tx = 1'b1;
        if (fh < nf && t >= fstart[fh]) begin
            k = (t - fstart[fh]) / DIV;
            if (k == 0) exp_tx = 1'b0;
            else if (k <= 8) exp_tx = fdata[fh][k-1];
        end
        exp_lvl  = acc - pp;
        exp_busy = (exp_lvl != 0) || (fh < nf && t >= fstart[fh] - 1);
        check("uart_tx", 32'(uart_tx), 32'(exp_tx));
        check("level", 32'(level), 32'(exp_lvl));
        check("in_ready", 32'(in_ready), 32'(exp_lvl != DEPTH));
        check("busy", 32'(busy), 32'(exp_busy));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] fill [6];
        int         i;
        int         s;
        t = 0; n_checks = 0; n_fail = 0;
        model_reset();
        resetn = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (4) step();
        resetn = 1'b1;
        idle(50);

        // Single frame, then three back-to-back frames.
        send(8'h55);
        idle(110);
        in_valid = 1'b1;
        in_data = 8'h00; step();
        in_data = 8'hFF; step();
        in_data = 8'hA3; step();
        idle(320);

        // Hold in_valid through a full FIFO; bytes advance only when accepted.
        for (int j = 0; j < 6; j++) fill[j] = 8'($urandom);
        i = 0;
        in_valid = 1'b1;
        in_data  = fill[0];
        for (int c = 0; c < 800 && i < 6; c++) begin
            step();
            if (last_acc) begin
                i++;
                if (i < 6) in_data = fill[i];
                else in_valid = 1'b0;
            end
        end
        check("fill_accepted", 32'(i), 32'd6);
        idle(700);

        // Random bursty traffic, often backing up against full.
        for (int c = 0; c < 3000; c++) begin
            in_valid = ($urandom_range(0, 14) == 0);
            in_data  = 8'($urandom);
            step();
        end
        idle(700);

        // Reset in the middle of data bit 3 of 0xC3 with another byte queued.
        send(8'hC3);
        send(8'h3C);
        s = fstart[nf-2];
        while (t < s + 45) step();
        resetn = 1'b0;
        #1;
        check("abort_tx", 32'(uart_tx), 32'd1);
        check("abort_level", 32'(level), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) step();
        resetn = 1'b1;
        idle(250);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
